reg_alu_pipe: RTL and testbench

Parametrised register-file/ALU datapath with two read ports and one write port, generalised in data width and register count. It adds a registered issue stage, one-cycle-deferred write-back with read-after-write forwarding, a valid handshake, a defined subtract op and a result output. It sits between the instruction sequencer (issue side) and downstream consumers of operands and results.

---
 rtl/reg_alu_pipe_pkg.sv | 13 +
 rtl/reg_alu_pipe_if.sv | 29 ++
 rtl/reg_alu_pipe_alu_w.sv | 37 +++
 rtl/reg_alu_pipe.sv | 86 ++++++++
 tb/tb_reg_alu_pipe.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/reg_alu_pipe_pkg.sv
// rtl/reg_alu_pipe_pkg.sv - shared op encodings and sizing helper for reg_alu_pipe
package reg_alu_pipe_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

    function automatic int nregs(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/reg_alu_pipe_if.sv
// rtl/reg_alu_pipe_if.sv - issue/operand/result bundle between sequencer and reg_alu_pipe
interface reg_alu_pipe_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              in_valid;
    logic              sel;
    logic              wr;
    logic [1:0]        op;
    logic [ADDR_W-1:0] rd_addr_a;
    logic [ADDR_W-1:0] rd_addr_b;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] d_in;
    logic [DATA_W-1:0] d_out_a;
    logic [DATA_W-1:0] d_out_b;
    logic [DATA_W-1:0] result;
    logic              cout;
    logic              out_valid;

    modport master (
        output in_valid, sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in,
        input  d_out_a, d_out_b, result, cout, out_valid
    );

    modport slave (
        input  in_valid, sel, wr, op, rd_addr_a, rd_addr_b, wr_addr, d_in,
        output d_out_a, d_out_b, result, cout, out_valid
    );
endinterface

// File: rtl/reg_alu_pipe_alu_w.sv
// rtl/reg_alu_pipe_alu_w.sv - combinational DATA_W ALU (add, sub, and, or) with carry
module alu_w
    import reg_alu_pipe_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [1:0]        op,
    output logic [DATA_W-1:0] y,
    output logic              carry
);

    logic [DATA_W:0] w_sum;

    always_comb begin
        w_sum = '0;
        y     = '0;
        carry = 1'b0;
        case (op)
            OP_ADD: begin
                w_sum = {1'b0, a} + {1'b0, b};
                y     = w_sum[DATA_W-1:0];
                carry = w_sum[DATA_W];
            end
            OP_SUB: begin
                // carry out of a + ~b + 1 is the no-borrow flag
                w_sum = {1'b0, a} + {1'b0, ~b} + {{DATA_W{1'b0}}, 1'b1};
                y     = w_sum[DATA_W-1:0];
                carry = w_sum[DATA_W];
            end
            OP_AND:  y = a & b;
            default: y = a | b;
        endcase
    end

endmodule

// File: rtl/reg_alu_pipe.sv
// rtl/reg_alu_pipe.sv - register file + ALU with registered issue, deferred write-back and forwarding
module reg_alu_pipe
    import reg_alu_pipe_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic           clk,
    input  logic           reset,
    reg_alu_pipe_if.slave  bus
);

    localparam int NREGS = nregs(ADDR_W);

    logic [DATA_W-1:0] r_regs [NREGS];
    logic              r_pend_valid;
    logic [ADDR_W-1:0] r_pend_addr;
    logic [DATA_W-1:0] r_pend_data;

    logic [DATA_W-1:0] r_d_out_a;
    logic [DATA_W-1:0] r_d_out_b;
    logic [DATA_W-1:0] r_result;
    logic              r_cout;
    logic              r_out_valid;

    logic [DATA_W-1:0] w_a;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_y;
    logic              w_carry;
    logic [DATA_W-1:0] w_wdata;

    // The pending write is not yet in the array, so reads of its address take it directly
    assign w_a = (r_pend_valid && (r_pend_addr == bus.rd_addr_a)) ? r_pend_data : r_regs[bus.rd_addr_a];
    assign w_b = (r_pend_valid && (r_pend_addr == bus.rd_addr_b)) ? r_pend_data : r_regs[bus.rd_addr_b];

    alu_w #(.DATA_W(DATA_W)) u_alu (
        .a     (w_a),
        .b     (w_b),
        .op    (bus.op),
        .y     (w_y),
        .carry (w_carry)
    );

    assign w_wdata = bus.sel ? w_y : bus.d_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
            r_pend_valid <= 1'b0;
            r_pend_addr  <= '0;
            r_pend_data  <= '0;
            r_d_out_a    <= '0;
            r_d_out_b    <= '0;
            r_result     <= '0;
            r_cout       <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            if (r_pend_valid) begin
                r_regs[r_pend_addr] <= r_pend_data;
            end
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_d_out_a    <= w_a;
                r_d_out_b    <= w_b;
                r_result     <= w_wdata;
                if (bus.sel) begin
                    r_cout <= w_carry;
                end
                r_pend_valid <= bus.wr;
                r_pend_addr  <= bus.wr_addr;
                r_pend_data  <= w_wdata;
            end else begin
                r_pend_valid <= 1'b0;
            end
        end
    end

    assign bus.d_out_a   = r_d_out_a;
    assign bus.d_out_b   = r_d_out_b;
    assign bus.result    = r_result;
    assign bus.cout      = r_cout;
    assign bus.out_valid = r_out_valid;

endmodule

// File: tb/tb_reg_alu_pipe.sv
// tb/tb_reg_alu_pipe.sv - self-checking bench for reg_alu_pipe against a sequential register-file model
module tb_reg_alu_pipe;
    import reg_alu_pipe_pkg::*;

    logic clk;
    logic reset;
    int   checks;
    int   errors;

    logic [7:0] m_regs [8];
    logic       m_cout;
    logic [7:0] exp_a;
    logic [7:0] exp_b;
    logic [7:0] exp_res;

    reg_alu_pipe_if #(.DATA_W(8), .ADDR_W(3)) ifc ();

    reg_alu_pipe #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (ifc.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Architectural view: each issue reads the state left by all earlier issues
    task automatic issue(input logic s, input logic w, input logic [1:0] o,
                         input logic [2:0] ra, input logic [2:0] rb,
                         input logic [2:0] wa, input logic [7:0] din);
        int a;
        int b;
        int y;
        logic c;
        ifc.in_valid  = 1'b1;
        ifc.sel       = s;
        ifc.wr        = w;
        ifc.op        = o;
        ifc.rd_addr_a = ra;
        ifc.rd_addr_b = rb;
        ifc.wr_addr   = wa;
        ifc.d_in      = din;
        a = int'(m_regs[ra]);
        b = int'(m_regs[rb]);
        case (o)
            OP_ADD:  begin y = (a + b) % 256;       c = (a + b) >= 256; end
            OP_SUB:  begin y = (a - b + 256) % 256; c = (a >= b);       end
            OP_AND:  begin y = a & b;               c = 1'b0;           end
            default: begin y = a | b;               c = 1'b0;           end
        endcase
        exp_a   = m_regs[ra];
        exp_b   = m_regs[rb];
        exp_res = s ? 8'(y) : din;
        if (s) m_cout = c;
        if (w) m_regs[wa] = exp_res;
        @(posedge clk);
        #1;
    endtask

    task automatic bubble();
        ifc.in_valid = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ifc.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_cout  = 1'b0;
        exp_a   = 8'h00;
        exp_b   = 8'h00;
        exp_res = 8'h00;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b exp 0", ifc.out_valid); end
        checks++; if (ifc.result !== 8'h00) begin errors++; $display("FAIL reset_result got %h exp 00", ifc.result); end
        checks++; if (ifc.cout !== 1'b0) begin errors++; $display("FAIL reset_cout got %0b exp 0", ifc.cout); end
        issue(1'b0, 1'b0, OP_ADD, 3'd3, 3'd5, 3'd0, 8'h00);
        checks++; if (ifc.out_valid !== 1'b1) begin errors++; $display("FAIL first_valid got %0b exp 1", ifc.out_valid); end
        checks++; if (ifc.d_out_a !== 8'h00 || ifc.d_out_b !== 8'h00) begin errors++; $display("FAIL first_ops got %h %h exp 00 00", ifc.d_out_a, ifc.d_out_b); end
        checks++; if (ifc.cout !== 1'b0) begin errors++; $display("FAIL first_cout got %0b exp 0", ifc.cout); end
        bubble();
    endtask

    task automatic test_forwarding();
        issue(1'b0, 1'b1, OP_ADD, 3'd0, 3'd0, 3'd2, 8'h5A);
        issue(1'b0, 1'b0, OP_ADD, 3'd2, 3'd2, 3'd0, 8'h00);
        checks++; if (ifc.d_out_a !== 8'h5A || ifc.d_out_b !== 8'h5A) begin errors++; $display("FAIL fwd_read got %h %h exp 5a 5a", ifc.d_out_a, ifc.d_out_b); end
        issue(1'b0, 1'b0, OP_ADD, 3'd2, 3'd2, 3'd0, 8'h00);
        checks++; if (ifc.d_out_a !== 8'h5A || ifc.d_out_b !== 8'h5A) begin errors++; $display("FAIL array_read got %h %h exp 5a 5a", ifc.d_out_a, ifc.d_out_b); end
        bubble();
    endtask

    task automatic test_add();
        issue(1'b0, 1'b1, OP_ADD, 3'd0, 3'd0, 3'd1, 8'hF0);
        issue(1'b0, 1'b1, OP_ADD, 3'd0, 3'd0, 3'd2, 8'h20);
        issue(1'b1, 1'b1, OP_ADD, 3'd1, 3'd2, 3'd3, 8'h00);
        checks++; if (ifc.result !== 8'h10) begin errors++; $display("FAIL add_result got %h exp 10", ifc.result); end
        checks++; if (ifc.cout !== 1'b1) begin errors++; $display("FAIL add_cout got %0b exp 1", ifc.cout); end
        bubble();
        bubble();
        issue(1'b0, 1'b0, OP_ADD, 3'd3, 3'd0, 3'd0, 8'h00);
        checks++; if (ifc.d_out_a !== 8'h10) begin errors++; $display("FAIL add_readback got %h exp 10", ifc.d_out_a); end
        bubble();
    endtask

    task automatic test_sub();
        issue(1'b0, 1'b1, OP_ADD, 3'd0, 3'd0, 3'd1, 8'h05);
        issue(1'b0, 1'b1, OP_ADD, 3'd0, 3'd0, 3'd2, 8'h07);
        issue(1'b1, 1'b0, OP_SUB, 3'd1, 3'd2, 3'd0, 8'h00);
        checks++; if (ifc.result !== 8'hFE || ifc.cout !== 1'b0) begin errors++; $display("FAIL sub_borrow got %h/%0b exp fe/0", ifc.result, ifc.cout); end
        issue(1'b1, 1'b0, OP_SUB, 3'd2, 3'd1, 3'd0, 8'h00);
        checks++; if (ifc.result !== 8'h02 || ifc.cout !== 1'b1) begin errors++; $display("FAIL sub_noborrow got %h/%0b exp 02/1", ifc.result, ifc.cout); end
        issue(1'b0, 1'b1, OP_AND, 3'd1, 3'd2, 3'd5, 8'h3C);
        checks++; if (ifc.result !== 8'h3C || ifc.cout !== 1'b1) begin errors++; $display("FAIL load_cout_hold got %h/%0b exp 3c/1", ifc.result, ifc.cout); end
        bubble();
    endtask

    task automatic test_back_to_back();
        issue(1'b0, 1'b1, OP_ADD, 3'd0, 3'd0, 3'd4, 8'h11);
        issue(1'b0, 1'b1, OP_ADD, 3'd4, 3'd0, 3'd4, 8'h22);
        checks++; if (ifc.d_out_a !== 8'h11) begin errors++; $display("FAIL b2b_fwd_first got %h exp 11", ifc.d_out_a); end
        issue(1'b0, 1'b0, OP_ADD, 3'd4, 3'd4, 3'd0, 8'h00);
        checks++; if (ifc.d_out_a !== 8'h22 || ifc.d_out_b !== 8'h22) begin errors++; $display("FAIL b2b_newest got %h %h exp 22 22", ifc.d_out_a, ifc.d_out_b); end
        bubble();
        checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid got %0b exp 0", ifc.out_valid); end
        checks++; if (ifc.d_out_a !== 8'h22 || ifc.result !== 8'h00) begin errors++; $display("FAIL bubble_hold got %h/%h exp 22/00", ifc.d_out_a, ifc.result); end
        issue(1'b0, 1'b0, OP_ADD, 3'd4, 3'd4, 3'd0, 8'h00);
        checks++; if (ifc.d_out_a !== 8'h22) begin errors++; $display("FAIL b2b_array got %h exp 22", ifc.d_out_a); end
        bubble();
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                bubble();
                checks++; if (ifc.out_valid !== 1'b0) begin errors++; $display("FAIL rnd_bubble_valid n=%0d got %0b exp 0", n, ifc.out_valid); end
            end else begin
                issue(1'($urandom), 1'($urandom), 2'($urandom), 3'($urandom), 3'($urandom),
                      3'($urandom), 8'($urandom));
                checks++; if (ifc.out_valid !== 1'b1) begin errors++; $display("FAIL rnd_valid n=%0d got %0b exp 1", n, ifc.out_valid); end
            end
            checks++;
            if (ifc.d_out_a !== exp_a || ifc.d_out_b !== exp_b || ifc.result !== exp_res || ifc.cout !== m_cout) begin
                errors++;
                $display("FAIL rnd_outputs n=%0d got a=%h b=%h r=%h c=%0b exp a=%h b=%h r=%h c=%0b",
                         n, ifc.d_out_a, ifc.d_out_b, ifc.result, ifc.cout, exp_a, exp_b, exp_res, m_cout);
            end
        end
        bubble();
    endtask

    task automatic test_reset_pending();
        issue(1'b0, 1'b1, OP_ADD, 3'd0, 3'd0, 3'd6, 8'h77);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        ifc.in_valid = 1'b0;
        for (int i = 0; i < 8; i++) m_regs[i] = 8'h00;
        m_cout = 1'b0;
        checks++;
        if (ifc.out_valid !== 1'b0 || ifc.d_out_a !== 8'h00 || ifc.d_out_b !== 8'h00 || ifc.result !== 8'h00 || ifc.cout !== 1'b0) begin
            errors++;
            $display("FAIL rst_outputs got v=%0b a=%h b=%h r=%h c=%0b exp all 0",
                     ifc.out_valid, ifc.d_out_a, ifc.d_out_b, ifc.result, ifc.cout);
        end
        bubble();
        issue(1'b0, 1'b0, OP_ADD, 3'd6, 3'd6, 3'd0, 8'h00);
        checks++; if (ifc.d_out_a !== 8'h00 || ifc.d_out_b !== 8'h00) begin errors++; $display("FAIL rst_r6 got %h %h exp 00 00", ifc.d_out_a, ifc.d_out_b); end
        bubble();
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b1;
        ifc.in_valid  = 1'b0;
        ifc.sel       = 1'b0;
        ifc.wr        = 1'b0;
        ifc.op        = 2'b00;
        ifc.rd_addr_a = 3'd0;
        ifc.rd_addr_b = 3'd0;
        ifc.wr_addr   = 3'd0;
        ifc.d_in      = 8'h00;
        @(posedge clk);
        #1;
        test_reset();
        test_forwarding();
        test_add();
        test_sub();
        test_back_to_back();
        test_random();
        test_reset_pending();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
